// File: rtl/ex_hazard_ctrl_pkg.sv
// Shared encodings for the EX hazard controller: forward selects, divider FSM states,
// register index width.
package ex_hazard_ctrl_pkg;

    localparam int REG_W = 5;

    typedef enum logic [1:0] {
        FWD_RF = 2'd0,
        FWD_EX = 2'd1,
        FWD_LS = 2'd2,
        FWD_WB = 2'd3
    } fwd_sel_e;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/ex_hazard_ctrl_if.sv
// ID/EX/LS/WB observation bundle and hazard-control outputs; master drives the pipeline
// view, slave is the hazard controller.
interface ex_hazard_ctrl_if;
    import ex_hazard_ctrl_pkg::*;

    logic             id_valid_i;
    logic [REG_W-1:0] id_rs1_i;
    logic [REG_W-1:0] id_rs2_i;
    logic             id_rs1_used_i;
    logic             id_rs2_used_i;
    logic             ex_valid_i;
    logic [REG_W-1:0] ex_rd_i;
    logic             ex_wen_i;
    logic             ex_is_load_i;
    logic             ex_div_en_i;
    logic [REG_W-1:0] ls_rd_i;
    logic             ls_wen_i;
    logic [REG_W-1:0] wb_rd_i;
    logic             wb_wen_i;
    logic             flush_i;
    logic [1:0]       rs1_sel_o;
    logic [1:0]       rs2_sel_o;
    logic             stall_id_o;
    logic             stall_ex_o;
    logic             bubble_ex_o;
    logic             div_start_o;
    logic             div_done_o;
    logic             div_busy_o;

    modport master (
        output id_valid_i, id_rs1_i, id_rs2_i, id_rs1_used_i, id_rs2_used_i,
               ex_valid_i, ex_rd_i, ex_wen_i, ex_is_load_i, ex_div_en_i,
               ls_rd_i, ls_wen_i, wb_rd_i, wb_wen_i, flush_i,
        input  rs1_sel_o, rs2_sel_o, stall_id_o, stall_ex_o, bubble_ex_o,
               div_start_o, div_done_o, div_busy_o
    );

    modport slave (
        input  id_valid_i, id_rs1_i, id_rs2_i, id_rs1_used_i, id_rs2_used_i,
               ex_valid_i, ex_rd_i, ex_wen_i, ex_is_load_i, ex_div_en_i,
               ls_rd_i, ls_wen_i, wb_rd_i, wb_wen_i, flush_i,
        output rs1_sel_o, rs2_sel_o, stall_id_o, stall_ex_o, bubble_ex_o,
               div_start_o, div_done_o, div_busy_o
    );

endinterface

// File: rtl/ex_hazard_ctrl_fwd_match.sv
// Per-source forward select: nearest producer wins (EX, then LS, then WB, else regfile).
// Purely combinational; no backpressure.
module ex_hazard_ctrl_fwd_match
    import ex_hazard_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] i_rs,
    input  logic             i_used,
    input  logic             i_ex_valid,
    input  logic             i_ex_wen,
    input  logic [REG_W-1:0] i_ex_rd,
    input  logic             i_ls_wen,
    input  logic [REG_W-1:0] i_ls_rd,
    input  logic             i_wb_wen,
    input  logic [REG_W-1:0] i_wb_rd,
    output fwd_sel_e         o_sel,
    output logic             o_ex_hit
);

    logic w_live;
    logic w_ls_hit;
    logic w_wb_hit;

    // x0 is hardwired zero, so it never takes a forwarded value.
    assign w_live   = i_used & (i_rs != '0);
    assign o_ex_hit = w_live & i_ex_valid & i_ex_wen & (i_ex_rd == i_rs);
    assign w_ls_hit = w_live & i_ls_wen & (i_ls_rd == i_rs);
    assign w_wb_hit = w_live & i_wb_wen & (i_wb_rd == i_rs);

    always_comb begin
        o_sel = FWD_RF;
        if (o_ex_hit)      o_sel = FWD_EX;
        else if (w_ls_hit) o_sel = FWD_LS;
        else if (w_wb_hit) o_sel = FWD_WB;
    end

endmodule

// File: rtl/ex_hazard_ctrl.sv
// EX scheduler: registered forward selects, load-use bubble, fixed-latency divider sequencing.
// Selects update one edge after ID; divider stalls ID/EX for DIV_CYCLES-1 cycles.
module ex_hazard_ctrl
    import ex_hazard_ctrl_pkg::*;
#(
    parameter int DIV_CYCLES = 64,
    parameter int CNT_W      = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    ex_hazard_ctrl_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_CYCLES - 2);

    div_state_e       r_state;
    div_state_e       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    fwd_sel_e         r_rs1_sel;
    fwd_sel_e         r_rs2_sel;
    fwd_sel_e         w_rs1_sel;
    fwd_sel_e         w_rs2_sel;
    logic             w_rs1_ex_hit;
    logic             w_rs2_ex_hit;
    logic             w_div_start;
    logic             w_div_done;
    logic             w_stall_ex;
    logic             w_load_use;
    logic             w_flush;
    logic             w_bubble;

    ex_hazard_ctrl_fwd_match u_fwd_rs1 (
        .i_rs       (bus.id_rs1_i),
        .i_used     (bus.id_rs1_used_i),
        .i_ex_valid (bus.ex_valid_i),
        .i_ex_wen   (bus.ex_wen_i),
        .i_ex_rd    (bus.ex_rd_i),
        .i_ls_wen   (bus.ls_wen_i),
        .i_ls_rd    (bus.ls_rd_i),
        .i_wb_wen   (bus.wb_wen_i),
        .i_wb_rd    (bus.wb_rd_i),
        .o_sel      (w_rs1_sel),
        .o_ex_hit   (w_rs1_ex_hit)
    );

    ex_hazard_ctrl_fwd_match u_fwd_rs2 (
        .i_rs       (bus.id_rs2_i),
        .i_used     (bus.id_rs2_used_i),
        .i_ex_valid (bus.ex_valid_i),
        .i_ex_wen   (bus.ex_wen_i),
        .i_ex_rd    (bus.ex_rd_i),
        .i_ls_wen   (bus.ls_wen_i),
        .i_ls_rd    (bus.ls_rd_i),
        .i_wb_wen   (bus.wb_wen_i),
        .i_wb_rd    (bus.wb_rd_i),
        .o_sel      (w_rs2_sel),
        .o_ex_hit   (w_rs2_ex_hit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= DIV_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // BUSY lasts DIV_CYCLES-2 cycles so start..done spans exactly DIV_CYCLES cycles.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_div_start = 1'b0;
        w_div_done  = 1'b0;
        w_stall_ex  = 1'b0;
        case (r_state)
            DIV_IDLE: begin
                if (bus.ex_valid_i && bus.ex_div_en_i) begin
                    w_div_start = 1'b1;
                    w_stall_ex  = 1'b1;
                    w_cnt_nxt   = CNT_LOAD;
                    w_state_nxt = (DIV_CYCLES == 2) ? DIV_DONE : DIV_BUSY;
                end
            end
            DIV_BUSY: begin
                w_stall_ex = 1'b1;
                w_cnt_nxt  = r_cnt - CNT_W'(1);
                if (r_cnt <= CNT_W'(1)) w_state_nxt = DIV_DONE;
            end
            DIV_DONE: begin
                w_div_done  = 1'b1;
                w_state_nxt = DIV_IDLE;
            end
            default: w_state_nxt = DIV_IDLE;
        endcase
    end

    // A frozen divide holds the EX instruction, so any redirect it raises is not yet real.
    assign w_load_use = bus.id_valid_i & (w_rs1_ex_hit | w_rs2_ex_hit) & bus.ex_is_load_i;
    assign w_flush    = bus.flush_i & ~w_stall_ex;
    assign w_bubble   = w_flush | (w_load_use & ~w_stall_ex);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rs1_sel <= FWD_RF;
            r_rs2_sel <= FWD_RF;
        end else if (!w_stall_ex) begin
            r_rs1_sel <= w_bubble ? FWD_RF : w_rs1_sel;
            r_rs2_sel <= w_bubble ? FWD_RF : w_rs2_sel;
        end
    end

    assign bus.rs1_sel_o   = r_rs1_sel;
    assign bus.rs2_sel_o   = r_rs2_sel;
    assign bus.stall_ex_o  = w_stall_ex;
    assign bus.stall_id_o  = w_stall_ex | (w_load_use & ~w_flush);
    assign bus.bubble_ex_o = w_bubble;
    assign bus.div_start_o = w_div_start;
    assign bus.div_done_o  = w_div_done;
    assign bus.div_busy_o  = (r_state != DIV_IDLE);

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Directed scenarios followed by randomized traffic checked against a cycle-age reference model.
module tb_ex_hazard_ctrl;
    import ex_hazard_ctrl_pkg::*;

    localparam int DIVC = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    // Reference state: cycles elapsed since divide start (0 = idle), expected select registers.
    int   m_age  = 0;
    int   m_sel1 = 0;
    int   m_sel2 = 0;

    ex_hazard_ctrl_if u_if();

    ex_hazard_ctrl #(.DIV_CYCLES(DIVC), .CNT_W(3)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clr();
        u_if.id_valid_i    = 1'b0;
        u_if.id_rs1_i      = '0;
        u_if.id_rs2_i      = '0;
        u_if.id_rs1_used_i = 1'b0;
        u_if.id_rs2_used_i = 1'b0;
        u_if.ex_valid_i    = 1'b0;
        u_if.ex_rd_i       = '0;
        u_if.ex_wen_i      = 1'b0;
        u_if.ex_is_load_i  = 1'b0;
        u_if.ex_div_en_i   = 1'b0;
        u_if.ls_rd_i       = '0;
        u_if.ls_wen_i      = 1'b0;
        u_if.wb_rd_i       = '0;
        u_if.wb_wen_i      = 1'b0;
        u_if.flush_i       = 1'b0;
    endtask

    function automatic int ref_sel(input int rs, input bit used);
        if (!used || rs == 0) return 0;
        if (u_if.ex_valid_i && u_if.ex_wen_i && int'(u_if.ex_rd_i) == rs) return 1;
        if (u_if.ls_wen_i && int'(u_if.ls_rd_i) == rs) return 2;
        if (u_if.wb_wen_i && int'(u_if.wb_rd_i) == rs) return 3;
        return 0;
    endfunction

    task automatic rand_phase(input int n);
        bit start, stall_ex, done, lu, fl, bubble, stall_id;
        int s1, s2;
        for (int i = 0; i < n; i++) begin
            u_if.id_valid_i    = 1'($urandom_range(0, 3) != 0);
            u_if.id_rs1_i      = 5'($urandom_range(0, 7));
            u_if.id_rs2_i      = 5'($urandom_range(0, 7));
            u_if.id_rs1_used_i = 1'($urandom);
            u_if.id_rs2_used_i = 1'($urandom);
            u_if.ex_valid_i    = 1'($urandom_range(0, 3) != 0);
            u_if.ex_rd_i       = 5'($urandom_range(0, 7));
            u_if.ex_wen_i      = 1'($urandom);
            u_if.ex_is_load_i  = 1'($urandom_range(0, 2) == 0);
            u_if.ex_div_en_i   = 1'($urandom_range(0, 11) == 0);
            u_if.ls_rd_i       = 5'($urandom_range(0, 7));
            u_if.ls_wen_i      = 1'($urandom);
            u_if.wb_rd_i       = 5'($urandom_range(0, 7));
            u_if.wb_wen_i      = 1'($urandom);
            u_if.flush_i       = 1'($urandom_range(0, 7) == 0);
            #1;
            start    = (m_age == 0) && u_if.ex_valid_i && u_if.ex_div_en_i;
            done     = (m_age == DIVC - 1);
            stall_ex = start || (m_age >= 1 && m_age < DIVC - 1);
            s1       = ref_sel(int'(u_if.id_rs1_i), u_if.id_rs1_used_i);
            s2       = ref_sel(int'(u_if.id_rs2_i), u_if.id_rs2_used_i);
            lu       = u_if.id_valid_i && u_if.ex_is_load_i && (s1 == 1 || s2 == 1);
            fl       = u_if.flush_i && !stall_ex;
            bubble   = fl || (lu && !stall_ex);
            stall_id = stall_ex || (lu && !fl);
            chk("r_sel1",   int'(u_if.rs1_sel_o),   m_sel1);
            chk("r_sel2",   int'(u_if.rs2_sel_o),   m_sel2);
            chk("r_stallex", int'(u_if.stall_ex_o), int'(stall_ex));
            chk("r_stallid", int'(u_if.stall_id_o), int'(stall_id));
            chk("r_bubble", int'(u_if.bubble_ex_o), int'(bubble));
            chk("r_start",  int'(u_if.div_start_o), int'(start));
            chk("r_done",   int'(u_if.div_done_o),  int'(done));
            chk("r_busy",   int'(u_if.div_busy_o),  int'(m_age >= 1));
            if (!stall_ex) begin
                m_sel1 = bubble ? 0 : s1;
                m_sel2 = bubble ? 0 : s2;
            end
            if (start)          m_age = 1;
            else if (done)      m_age = 0;
            else if (m_age > 0) m_age = m_age + 1;
            cyc();
        end
    endtask

    initial begin
        int seen_done;
        clr();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_sel1",    int'(u_if.rs1_sel_o),   0);
        chk("rst_sel2",    int'(u_if.rs2_sel_o),   0);
        chk("rst_busy",    int'(u_if.div_busy_o),  0);
        chk("rst_stallid", int'(u_if.stall_id_o),  0);
        chk("rst_bubble",  int'(u_if.bubble_ex_o), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Forwarding priority for rs1 = 5 across EX / LS / WB, then x0.
        u_if.id_valid_i = 1'b1; u_if.id_rs1_i = 5'd5; u_if.id_rs1_used_i = 1'b1;
        u_if.ex_valid_i = 1'b1; u_if.ex_rd_i = 5'd5; u_if.ex_wen_i = 1'b1;
        cyc();
        chk("fwd_ex", int'(u_if.rs1_sel_o), 1);
        u_if.ex_wen_i = 1'b0; u_if.ls_rd_i = 5'd5; u_if.ls_wen_i = 1'b1;
        cyc();
        chk("fwd_ls", int'(u_if.rs1_sel_o), 2);
        u_if.ls_wen_i = 1'b0; u_if.wb_rd_i = 5'd5; u_if.wb_wen_i = 1'b1;
        cyc();
        chk("fwd_wb", int'(u_if.rs1_sel_o), 3);
        u_if.wb_wen_i = 1'b0; u_if.id_rs1_i = 5'd0; u_if.ex_rd_i = 5'd0; u_if.ex_wen_i = 1'b1;
        cyc();
        chk("fwd_x0", int'(u_if.rs1_sel_o), 0);

        // Load-use on rs2 = 7.
        clr();
        u_if.id_valid_i = 1'b1; u_if.id_rs2_i = 5'd7; u_if.id_rs2_used_i = 1'b1;
        u_if.ex_valid_i = 1'b1; u_if.ex_rd_i = 5'd7; u_if.ex_wen_i = 1'b1; u_if.ex_is_load_i = 1'b1;
        #1;
        chk("lu_stallid", int'(u_if.stall_id_o),  1);
        chk("lu_bubble",  int'(u_if.bubble_ex_o), 1);
        chk("lu_stallex", int'(u_if.stall_ex_o),  0);
        cyc();
        u_if.ex_valid_i = 1'b0; u_if.ex_wen_i = 1'b0; u_if.ex_is_load_i = 1'b0;
        u_if.ls_rd_i = 5'd7; u_if.ls_wen_i = 1'b1;
        #1;
        chk("lu2_stallid", int'(u_if.stall_id_o),  0);
        chk("lu2_bubble",  int'(u_if.bubble_ex_o), 0);
        cyc();
        chk("lu_sel2_ls", int'(u_if.rs2_sel_o), 2);

        // Divide with sels (0,2) held while ID would compute (3,0).
        clr();
        u_if.id_valid_i = 1'b1; u_if.id_rs1_i = 5'd9; u_if.id_rs1_used_i = 1'b1;
        u_if.wb_rd_i = 5'd9; u_if.wb_wen_i = 1'b1;
        u_if.ex_valid_i = 1'b1; u_if.ex_div_en_i = 1'b1;
        #1;
        chk("div0_start",   int'(u_if.div_start_o), 1);
        chk("div0_stallex", int'(u_if.stall_ex_o),  1);
        chk("div0_stallid", int'(u_if.stall_id_o),  1);
        for (int c = 1; c < DIVC - 1; c++) begin
            cyc();
            chk("divb_start",   int'(u_if.div_start_o), 0);
            chk("divb_stallex", int'(u_if.stall_ex_o),  1);
            chk("divb_busy",    int'(u_if.div_busy_o),  1);
            chk("divb_sel1",    int'(u_if.rs1_sel_o),   0);
            chk("divb_sel2",    int'(u_if.rs2_sel_o),   2);
        end
        cyc();
        chk("div_done",    int'(u_if.div_done_o), 1);
        chk("div_done_se", int'(u_if.stall_ex_o), 0);
        chk("div_done_s1", int'(u_if.rs1_sel_o),  0);
        chk("div_done_s2", int'(u_if.rs2_sel_o),  2);
        cyc();
        chk("div2_start", int'(u_if.div_start_o), 1);
        chk("div2_sel1",  int'(u_if.rs1_sel_o),   3);
        chk("div2_sel2",  int'(u_if.rs2_sel_o),   0);
        for (int c = 1; c < DIVC - 1; c++) begin
            cyc();
            chk("div2b_stallex", int'(u_if.stall_ex_o), 1);
            chk("div2b_done",    int'(u_if.div_done_o), 0);
        end
        cyc();
        chk("div2_done", int'(u_if.div_done_o), 1);
        cyc();

        // Load-use coinciding with flush: flush wins.
        u_if.ex_div_en_i = 1'b0; u_if.ex_is_load_i = 1'b1; u_if.ex_wen_i = 1'b1;
        u_if.ex_rd_i = 5'd7; u_if.id_rs2_i = 5'd7; u_if.id_rs2_used_i = 1'b1; u_if.flush_i = 1'b1;
        #1;
        chk("fl_pre_sel1", int'(u_if.rs1_sel_o),   3);
        chk("fl_bubble",   int'(u_if.bubble_ex_o), 1);
        chk("fl_stallid",  int'(u_if.stall_id_o),  0);
        cyc();
        chk("fl_sel1", int'(u_if.rs1_sel_o), 0);
        chk("fl_sel2", int'(u_if.rs2_sel_o), 0);

        // Reset while BUSY aborts without a done pulse.
        clr();
        u_if.ex_valid_i = 1'b1; u_if.ex_div_en_i = 1'b1;
        cyc();
        u_if.ex_valid_i = 1'b0;
        #1;
        chk("rb_busy", int'(u_if.div_busy_o), 1);
        rst_n = 1'b0;
        #1;
        chk("rb_rst_busy",    int'(u_if.div_busy_o), 0);
        chk("rb_rst_stallex", int'(u_if.stall_ex_o), 0);
        chk("rb_rst_done",    int'(u_if.div_done_o), 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 0;
        for (int c = 0; c < 2 * DIVC; c++) begin
            cyc();
            if (u_if.div_done_o) seen_done++;
        end
        chk("rb_no_done", seen_done, 0);

        // Randomized traffic against the reference model.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_age = 0; m_sel1 = 0; m_sel2 = 0;
        rand_phase(3000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
